// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with per-register busy scoreboard and writeback forwarding
module reg_file_sb #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int BYPASS       = 1,
    localparam int AW          = $clog2(NUM_REGS),
    localparam int CW          = $clog2(NUM_REGS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD_PORTS*AW-1:0]   rd_addr,
    output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]      rd_busy,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [XLEN-1:0]              wr_data,
    input  logic                         rsv_en,
    input  logic [AW-1:0]                rsv_addr,
    output logic                         rsv_ok,
    input  logic                         flush,
    output logic [CW-1:0]                busy_count
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                wr_act;
    logic                wr_hits_rsv;

    // Gating on rst keeps forwarding and acceptance quiet while reset is held.
    assign wr_act      = rst && wr_en && (wr_addr != '0);
    assign wr_hits_rsv = wr_act && (wr_addr == rsv_addr);
    assign rsv_ok      = rst && rsv_en && !flush &&
                         ((rsv_addr == '0) || !busy_q[rsv_addr] || wr_hits_rsv);

    genvar p;
    for (p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = rd_addr[p*AW +: AW];
        assign fwd = (BYPASS != 0) && wr_act && (wr_addr == ra);
        assign rd_data[p*XLEN +: XLEN] = (ra == '0) ? '0 :
                                         fwd        ? wr_data : regs_q[ra];
        assign rd_busy[p] = (ra != '0) && !fwd && busy_q[ra];
    end

    // Write clears ownership first so a same-cycle reservation becomes the new owner.
    always_comb begin
        busy_d = busy_q;
        if (wr_act) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            if (wr_act) begin
                regs_q[wr_addr] <= wr_data;
            end
        end
    end

    assign busy_count = count_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb, forwarding and non-forwarding builds
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    logic [63:0] rd_data1, rd_data0;
    logic [1:0]  rd_busy1, rd_busy0;
    logic        rsv_ok1, rsv_ok0;
    logic [5:0]  bc1, bc0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mreg  [32];
    logic        mbusy [32];

    reg_file_sb #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok1), .flush(flush), .busy_count(bc1)
    );

    reg_file_sb #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .rsv_ok(rsv_ok0), .flush(flush), .busy_count(bc0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    function automatic logic [32:0] exp_read(input logic [4:0] a, input bit byp);
        if (a == 0) return 33'd0;
        if (byp && wr_en && wr_addr == a) return {1'b0, wr_data};
        return {mbusy[a], mreg[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'd0;
            mbusy[i] = 1'b0;
        end
    endtask

    task automatic step();
        logic [32:0] e;
        logic        ok;
        #1;
        for (int p = 0; p < 2; p++) begin
            e = exp_read(rd_addr[p*5 +: 5], 1'b1);
            chk($sformatf("byp_data%0d", p), {32'd0, rd_data1[p*32 +: 32]}, {32'd0, e[31:0]});
            chk($sformatf("byp_busy%0d", p), {63'd0, rd_busy1[p]}, {63'd0, e[32]});
        end
        e = exp_read(rd_addr[4:0], 1'b0);
        chk("nobyp_data0", {32'd0, rd_data0[31:0]}, {32'd0, e[31:0]});
        chk("nobyp_busy0", {63'd0, rd_busy0[0]}, {63'd0, e[32]});
        ok = rsv_en && !flush &&
             (rsv_addr == 0 || !mbusy[rsv_addr] || (wr_en && wr_addr == rsv_addr));
        chk("rsv_ok", {63'd0, rsv_ok1}, {63'd0, ok});
        chk("rsv_ok_nobyp", {63'd0, rsv_ok0}, {63'd0, ok});
        @(posedge clk);
        if (wr_en && wr_addr != 0) begin
            mreg[wr_addr]  = wr_data;
            mbusy[wr_addr] = 1'b0;
        end
        if (ok && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
        if (flush) for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        #1;
        chk("busy_count", {58'd0, bc1}, 64'(model_count()));
        chk("busy_count_nobyp", {58'd0, bc0}, 64'(model_count()));
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra, input logic fl,
                         input logic [4:0] a0, input logic [4:0] a1);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; flush = fl;
        rd_addr = {a1, a0};
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, rd_data1, 64'd0);
        chk({tag, "_data_nobyp"}, rd_data0, 64'd0);
        chk({tag, "_busy"}, {62'd0, rd_busy1}, 64'd0);
        chk({tag, "_count"}, {58'd0, bc1}, 64'd0);
        chk({tag, "_rsv_ok"}, {63'd0, rsv_ok1}, 64'd0);
    endtask

    initial begin
        rst = 1'b0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        rsv_en = 0; rsv_addr = '0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_init");
        @(negedge clk);
        rst = 1'b1;

        for (int a = 0; a < 32; a += 2)
            drive(0, 0, 0, 0, 0, 0, 5'(a), 5'(a + 1));

        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
        drive(0, 0, 0, 0, 0, 0, 5, 0);

        drive(0, 0, 0, 1, 7, 0, 7, 0);
        drive(0, 0, 0, 1, 7, 0, 7, 7);
        drive(1, 7, 32'h0000_0077, 0, 0, 0, 7, 0);

        drive(0, 0, 0, 1, 7, 0, 7, 0);
        drive(1, 7, 32'h0000_7777, 1, 7, 0, 7, 7);
        drive(0, 0, 0, 0, 0, 0, 7, 0);

        drive(0, 0, 0, 1, 1, 0, 1, 0);
        drive(0, 0, 0, 1, 2, 0, 2, 0);
        drive(0, 0, 0, 1, 3, 0, 3, 0);
        drive(1, 2, 32'h55, 1, 4, 1, 2, 3);
        drive(0, 0, 0, 0, 0, 0, 2, 3);

        drive(1, 0, 32'h1234, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 15) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        drive(0, 0, 0, 1, 9, 0, 2, 9);
        drive(0, 0, 0, 1, 10, 0, 2, 10);
        @(negedge clk);
        wr_en = 1; wr_addr = 2; wr_data = 32'hA5A5_A5A5;
        rsv_en = 1; rsv_addr = 11; flush = 0; rd_addr = {5'd10, 5'd2};
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        model_reset();
        @(negedge clk);
        wr_en = 0; rsv_en = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2, 10);
        drive(0, 0, 0, 1, 10, 0, 10, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
